extend_unit_pipe: RTL

Parametrised, pipelined immediate extender for the decode stage. Accepts the 24-bit instruction immediate field plus a 3-bit mode and produces a DATA_W-wide extended immediate through a 2-stage valid/ready pipeline. Adds ARM rotated-imm8 and imm24 modes and an illegal-mode flag and counter. It sits between the instruction decoder and the register-read/ALU operand mux.

---
 rtl/extend_unit_pipe_if.sv | 26 ++
 rtl/extend_unit_pipe.sv | 114 +++++++++++
 2 files changed

// File: rtl/extend_unit_pipe_if.sv
// Valid/ready bundle between the instruction decoder (master) and the
// pipelined immediate extender (slave).
interface extend_unit_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [23:0]       in_inst;
    logic [2:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic              out_illegal;

    // Decoder side: offers instruction beats, consumes extended immediates.
    modport master (
        output in_valid, in_inst, in_mode, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal
    );

    // Extender side.
    modport slave (
        input  in_valid, in_inst, in_mode, out_ready,
        output in_ready, out_valid, out_imm, out_illegal
    );
endinterface

// File: rtl/extend_unit_pipe.sv
// Two-stage valid/ready immediate extender for the decode stage.
// Stage 1 holds the raw immediate field and mode, stage 2 holds the
// extended result. Illegal modes yield a zero immediate with a flag and
// bump a saturating counter at input acceptance.
module extend_unit_pipe #(
    parameter int DATA_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    extend_unit_pipe_if.slave   bus,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        MODE_ZX8  = 3'b000,
        MODE_ZX12 = 3'b001,
        MODE_BR   = 3'b010,
        MODE_ROT  = 3'b011,
        MODE_ZX24 = 3'b100
    } mode_e;

    logic                s1_valid_q;
    logic [23:0]         s1_inst_q;
    logic [2:0]          s1_mode_q;
    logic                s2_valid_q;
    logic [DATA_W-1:0]   s2_imm_q;
    logic                s2_illegal_q;
    logic [ERRCNT_W-1:0] err_count_q;

    logic                s2_adv;
    logic                s1_adv;
    logic                accept;
    logic                illegal_accept;
    logic [31:0]         rot_src;
    logic [31:0]         rot_val;
    logic [DATA_W-1:0]   imm_d;
    logic                illegal_d;

    // Stage 2 moves whenever it is empty or drained; stage 1 whenever it is
    // empty or can hand its beat forward. Empty slots therefore collapse.
    assign s2_adv         = !s2_valid_q || bus.out_ready;
    assign s1_adv         = !s1_valid_q || s2_adv;
    assign accept         = bus.in_valid && s1_adv;
    assign illegal_accept = accept && (bus.in_mode > MODE_ZX24);

    // Right rotation by 2*rot within 32 bits: the low word of a doubled
    // copy shifted right by the rotate amount.
    assign rot_src = {24'd0, s1_inst_q[7:0]};
    assign rot_val = 32'({rot_src, rot_src} >> {s1_inst_q[11:8], 1'b0});

    // Extend the stage-1 immediate according to its mode.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        imm_d     = '0;
        illegal_d = 1'b0;
        case (s1_mode_q)
            MODE_ZX8:  imm_d = DATA_W'(s1_inst_q[7:0]);
            MODE_ZX12: imm_d = DATA_W'(s1_inst_q[11:0]);
            MODE_BR:   imm_d = {{(DATA_W-26){s1_inst_q[23]}}, s1_inst_q, 2'b00};
            MODE_ROT:  imm_d = DATA_W'(rot_val);
            MODE_ZX24: imm_d = DATA_W'(s1_inst_q);
            default:   illegal_d = 1'b1;
        endcase
    end

    // Stage 1: capture the fields of an accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of block ordering.
            s1_valid_q <= 1'b0;
            s1_inst_q  <= '0;
            s1_mode_q  <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_inst_q <= bus.in_inst;
                s1_mode_q <= bus.in_mode;
            end
        end
    end

    // Stage 2: register the extended result; holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q   <= 1'b0;
            s2_imm_q     <= '0;
            s2_illegal_q <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_imm_q     <= imm_d;
                s2_illegal_q <= illegal_d;
            end
        end
    end

    // Saturating count of illegal beats accepted at the input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= '0;
        end else if (illegal_accept && (err_count_q != '1)) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    assign bus.in_ready    = s1_adv;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_imm     = s2_imm_q;
    assign bus.out_illegal = s2_illegal_q;
    assign err_count       = err_count_q;

endmodule
